// File: rtl/mux2_pkg.sv
// mux2_pkg: shared select encodings and default data width for the mux2 arbiter slice
package mux2_pkg;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int W_DEF = 8;
endpackage

// File: rtl/mux2_sat_cnt.sv
// mux2_sat_cnt: saturating up-counter, holds at all-ones instead of wrapping
module mux2_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/mux2_rr_arb.sv
// mux2_rr_arb: two-channel round-robin stream arbiter with a registered output entry
// Optional grant counters when MUX2_ARB_CNT_EN is defined.
module mux2_rr_arb
  import mux2_pkg::*;
#(
  parameter int W = W_DEF
`ifdef MUX2_ARB_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sel,
  input  logic         out_ready
`ifdef MUX2_ARB_CNT_EN
  , output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
`endif
);
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_out_sel;
  logic         r_last;
  logic         w_load;
  logic         w_grant_a;
  logic         w_grant_b;
  assign w_load    = !r_out_valid | out_ready;
  // Under contention the channel that did not win last time takes the grant.
  assign w_grant_a = a_valid & (!b_valid | r_last == SEL_B);
  assign w_grant_b = b_valid & (!a_valid | r_last == SEL_A);
  assign a_ready   = !rst & w_load & w_grant_a;
  assign b_ready   = !rst & w_load & w_grant_b;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= SEL_A;
      r_last      <= SEL_B;
    end else if (w_load) begin
      r_out_valid <= a_ready | b_ready;
      if (a_ready | b_ready) begin
        r_out_data <= a_ready ? a_data : b_data;
        r_out_sel  <= a_ready ? SEL_A : SEL_B;
        r_last     <= a_ready ? SEL_A : SEL_B;
      end
    end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
`ifdef MUX2_ARB_CNT_EN
  mux2_sat_cnt #(.CNT_W(CNT_W)) u_a_cnt (.clk(clk), .rst(rst), .i_inc(a_ready), .o_cnt(a_cnt));
  mux2_sat_cnt #(.CNT_W(CNT_W)) u_b_cnt (.clk(clk), .rst(rst), .i_inc(b_ready), .o_cnt(b_cnt));
`endif
endmodule

// File: tb/tb_mux2_rr_arb.sv
// tb_mux2_rr_arb: scoreboard bench for mux2_rr_arb; checks counters too when MUX2_ARB_CNT_EN is defined
module tb_mux2_rr_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_data, b_data, out_data;
  logic       out_valid, out_sel, out_ready;
  int         total = 0;
  int         bad = 0;
  logic [8:0] q[$];
  logic       m_last, m_ov, m_sel;
  logic [7:0] m_data;
`ifdef MUX2_ARB_CNT_EN
  logic [1:0] a_cnt, b_cnt, m_acnt, m_bcnt;
  mux2_rr_arb #(.W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready), .a_cnt(a_cnt), .b_cnt(b_cnt));
`else
  mux2_rr_arb #(.W(8)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_last = 1'b1;
    m_ov = 1'b0;
    m_data = '0;
    m_sel = 1'b0;
    q.delete();
`ifdef MUX2_ARB_CNT_EN
    m_acnt = '0;
    m_bcnt = '0;
`endif
  endtask
  task automatic step(input logic av, input logic bv, input logic [7:0] ad, input logic [7:0] bd, input logic ordy);
    logic load, ga, gb;
    logic [8:0] e;
    a_valid = av; b_valid = bv; a_data = ad; b_data = bd; out_ready = ordy;
    #1;
    load = !m_ov | ordy;
    ga = av & (!bv | m_last);
    gb = bv & (!av | !m_last);
    chk("a_ready", a_ready, load & ga);
    chk("b_ready", b_ready, load & gb);
    if (load & (ga | gb)) begin
      q.push_back(ga ? {1'b0, ad} : {1'b1, bd});
      m_last = gb;
`ifdef MUX2_ARB_CNT_EN
      if (ga && m_acnt != 2'd3) m_acnt++;
      if (gb && m_bcnt != 2'd3) m_bcnt++;
`endif
    end
    if (load) m_ov = ga | gb;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      m_sel = e[8];
      m_data = e[7:0];
    end
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
`ifdef MUX2_ARB_CNT_EN
    chk("a_cnt", a_cnt, m_acnt);
    chk("b_cnt", b_cnt, m_bcnt);
`endif
  endtask
  initial begin
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h55; b_data = 8'h66; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    rst = 1'b0;
    repeat (4) step(1, 1, 8'hA0, 8'hB0, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 8'h00);
    chk("midrst_out_sel", out_sel, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 1, 8'h11, 8'h22, 1);
    chk("first_after_rst", {out_sel, out_data}, 9'h011);
    repeat (4) step(1, 1, 8'hA0, 8'hB0, 1);
    repeat (4) step(0, 1, 8'h00, 8'hC3, 1);
    step(1, 1, 8'hA5, 8'hB5, 1);
    chk("a_after_b_run", out_sel, 1'b0);
    repeat (3) step(1, 1, 8'hA7, 8'hB7, 0);
    step(1, 1, 8'hA8, 8'hB8, 1);
    step(0, 0, 8'h00, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 1);
    step(0, 0, 8'h00, 8'h00, 1);
    repeat (8) step(1, 0, 8'h3C, 8'h00, 1);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
